// File: rtl/commit_trace_buffer_pkg.sv
// trace_pkg: shared kinds, entry layout and FSM encoding
// for the commit trace buffer.
package trace_pkg;

    localparam logic [1:0] KIND_REG   = 2'd0;
    localparam logic [1:0] KIND_HALT  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;
    localparam logic [1:0] KIND_OTHER = 2'd3;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_t;

    // Entry layout, LSB first: data, addr, reg, pc, kind
    function automatic int entryW(input int pcW, input int regW);
        return 2 + regW + 3 * pcW;
    endfunction

    function automatic int offAddr(input int pcW);
        return pcW;
    endfunction

    function automatic int offReg(input int pcW);
        return 2 * pcW;
    endfunction

    function automatic int offPc(input int pcW, input int regW);
        return 2 * pcW + regW;
    endfunction

    function automatic int offKind(input int pcW, input int regW);
        return 3 * pcW + regW;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: retire bundle in, trace
// entries out over a valid/ready read port.
interface commit_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int REG_W = 4
);
    localparam int EW = entryW(PC_W, REG_W);

    logic             ret_valid;
    logic [PC_W-1:0]  ret_pc;
    logic             ret_regwrite;
    logic [REG_W-1:0] ret_reg;
    logic [PC_W-1:0]  ret_wdata;
    logic             ret_memwrite;
    logic [PC_W-1:0]  ret_memaddr;
    logic [PC_W-1:0]  ret_memdata;
    logic             ret_halt;
    logic             rd_ready;
    logic             rd_valid;
    logic [EW-1:0]    rd_entry;

    modport master (
        output ret_valid, ret_pc, ret_regwrite, ret_reg,
        output ret_wdata, ret_memwrite, ret_memaddr,
        output ret_memdata, ret_halt, rd_ready,
        input  rd_valid, rd_entry
    );

    modport slave (
        input  ret_valid, ret_pc, ret_regwrite, ret_reg,
        input  ret_wdata, ret_memwrite, ret_memaddr,
        input  ret_memdata, ret_halt, rd_ready,
        output rd_valid, rd_entry
    );

endinterface

// File: rtl/commit_trace_buffer_fifo_mem.sv
// trace_fifo_mem: DEPTH x W register array,
// one synchronous write port, one async read port.
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wAddr,
    input  logic [W-1:0]  wData,
    input  logic [AW-1:0] rAddr,
    output logic [W-1:0]  rData
);

    logic [W-1:0] mem [DEPTH];

    // Store one entry per cycle at the write pointer
    always_ff @(posedge clk) begin
        if (we) mem[wAddr] <= wData;
    end

    assign rData = mem[rAddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: classifies each retire, logs it in a
// circular buffer, counts, and freezes on halt or watchdog.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int PC_W       = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int WRAP_MODE  = 0,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    commit_trace_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [CNT_W-1:0]        inst_count,
    output logic [CNT_W-1:0]        cycle_count,
    output logic                    overflow,
    output logic                    frozen,
    output logic                    limit_hit
);

    localparam int AW     = $clog2(DEPTH);
    localparam int EW     = entryW(PC_W, REG_W);
    localparam int O_ADDR = offAddr(PC_W);
    localparam int O_REG  = offReg(PC_W);
    localparam int O_PC   = offPc(PC_W, REG_W);
    localparam int O_KIND = offKind(PC_W, REG_W);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);
    localparam bit WDOG = (MAX_CYCLES != 0);
    localparam bit WRAP = (WRAP_MODE != 0);

    state_t        state;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [1:0]    kind;
    logic [EW-1:0] entry;
    logic          push, pop, full, blocked;
    logic          drop, overwrite, doWrite;
    logic          haltIn, wdogHit;

    // occupancy never exceeds DEPTH, so its MSB alone means full
    assign full         = occupancy[AW];
    assign bus.rd_valid = |occupancy;
    assign frozen       = (state == FROZEN);
    assign push         = bus.ret_valid && (state == RUN);
    assign pop          = bus.rd_valid && bus.rd_ready;
    assign blocked      = push && full && !pop;
    assign drop         = blocked && !WRAP;
    assign overwrite    = blocked && WRAP;
    assign doWrite      = push && !drop;
    assign haltIn       = push && (kind == KIND_HALT);
    assign wdogHit      = WDOG && (state == RUN) && (cycle_count == LIMIT);

    // Classify the retire: REG > HALT > STORE > OTHER
    always_comb begin
        kind = KIND_OTHER;
        if (bus.ret_regwrite)      kind = KIND_REG;
        else if (bus.ret_halt)     kind = KIND_HALT;
        else if (bus.ret_memwrite) kind = KIND_STORE;
    end

    // Pack the entry; unused fields of a kind read as zero
    always_comb begin
        entry = '0;
        entry[O_KIND +: 2]  = kind;
        entry[O_PC +: PC_W] = bus.ret_pc;
        if (kind == KIND_REG) begin
            entry[O_REG +: REG_W] = bus.ret_reg;
            entry[O_ADDR +: PC_W] = bus.ret_memaddr;
            entry[0 +: PC_W]      = bus.ret_wdata;
        end else if (kind == KIND_STORE) begin
            entry[O_ADDR +: PC_W] = bus.ret_memaddr;
            entry[0 +: PC_W]      = bus.ret_memdata;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (doWrite),
        .wAddr (wrPtr),
        .wData (entry),
        .rAddr (rdPtr),
        .rData (bus.rd_entry)
    );

    // Pointers and occupancy; an overwrite drags the head forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else if (clr) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + AW'(1);
            if (pop || overwrite) rdPtr <= rdPtr + AW'(1);
            if (doWrite && !overwrite && !pop)
                occupancy <= occupancy + (AW+1)'(1);
            else if (pop && !doWrite)
                occupancy <= occupancy - (AW+1)'(1);
        end
    end

    // Saturating instruction and cycle counters, live only in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count  <= '0;
            cycle_count <= '0;
        end else if (clr) begin
            inst_count  <= '0;
            cycle_count <= '0;
        end else if (state == RUN) begin
            if (~&cycle_count)
                cycle_count <= cycle_count + CNT_W'(1);
            if (bus.ret_valid && ~&inst_count)
                inst_count <= inst_count + CNT_W'(1);
        end
    end

    // RUN/FROZEN state and the sticky overflow/limit flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            overflow  <= 1'b0;
            limit_hit <= 1'b0;
        end else if (clr) begin
            state     <= RUN;
            overflow  <= 1'b0;
            limit_hit <= 1'b0;
        end else begin
            if (drop || overwrite) overflow <= 1'b1;
            if (wdogHit) limit_hit <= 1'b1;
            if (haltIn || wdogHit) state <= FROZEN;
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: three DUT variants (stop, wrap, watchdog=10)
// share one stimulus stream and are checked against queue models.
module tb_commit_trace_buffer;

    localparam int EW    = 54;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr   = 1'b0;
    logic        v = 1'b0, rw = 1'b0, mw = 1'b0, hl = 1'b0, rdy = 1'b0;
    logic [15:0] pc = '0, wd = '0, ma = '0, md = '0;
    logic [3:0]  rg = '0;

    logic          rv  [3];
    logic [EW-1:0] re  [3];
    logic [2:0]    occ [3];
    logic [31:0]   ic  [3];
    logic [31:0]   cc  [3];
    logic          ov  [3];
    logic          fz  [3];
    logic          lh  [3];

    int nVec = 0;
    int nErr = 0;

    logic [EW-1:0] mq [3][$];
    logic [31:0]   mIc [3];
    logic [31:0]   mCc [3];
    bit            mOv [3];
    bit            mFz [3];
    bit            mLh [3];

    logic [EW-1:0] expE;

    always #5 clk = ~clk;

    commit_trace_buffer_if #(.PC_W(16), .REG_W(4)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : gDut
        assign bus[g].ret_valid    = v;
        assign bus[g].ret_pc       = pc;
        assign bus[g].ret_regwrite = rw;
        assign bus[g].ret_reg      = rg;
        assign bus[g].ret_wdata    = wd;
        assign bus[g].ret_memwrite = mw;
        assign bus[g].ret_memaddr  = ma;
        assign bus[g].ret_memdata  = md;
        assign bus[g].ret_halt     = hl;
        assign bus[g].rd_ready     = rdy;
        assign rv[g] = bus[g].rd_valid;
        assign re[g] = bus[g].rd_entry;

        commit_trace_buffer #(
            .PC_W       (16),
            .REG_W      (4),
            .DEPTH      (DEPTH),
            .CNT_W      (32),
            .WRAP_MODE  (g == 1 ? 1 : 0),
            .MAX_CYCLES (g == 0 ? 0 : (g == 1 ? 100000 : 10))
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr         (clr),
            .bus         (bus[g]),
            .occupancy   (occ[g]),
            .inst_count  (ic[g]),
            .cycle_count (cc[g]),
            .overflow    (ov[g]),
            .frozen      (fz[g]),
            .limit_hit   (lh[g])
        );
    end

    function automatic bit mWrap(input int i);
        return i == 1;
    endfunction

    function automatic int mMax(input int i);
        return i == 0 ? 0 : (i == 1 ? 100000 : 10);
    endfunction

    function automatic logic [EW-1:0] mkEntry();
        if (rw) return {2'd0, pc, rg, ma, wd};
        if (hl) return {2'd1, pc, 4'd0, 16'd0, 16'd0};
        if (mw) return {2'd2, pc, 4'd0, ma, md};
        return {2'd3, pc, 4'd0, 16'd0, 16'd0};
    endfunction

    task automatic mReset(input int i);
        mq[i].delete();
        mIc[i] = '0;
        mCc[i] = '0;
        mOv[i] = 1'b0;
        mFz[i] = 1'b0;
        mLh[i] = 1'b0;
    endtask

    task automatic mStep(input int i);
        logic [EW-1:0] e;
        bit doPop, doPush, wdog;
        if (clr) begin
            mReset(i);
            return;
        end
        e = mkEntry();
        doPop = rdy && (mq[i].size() > 0);
        doPush = 1'b0;
        if (!mFz[i]) begin
            wdog = (mMax(i) != 0) && (mCc[i] == 32'(mMax(i) - 1));
            if (mCc[i] != '1) mCc[i] = mCc[i] + 1;
            if (v) begin
                if (mIc[i] != '1) mIc[i] = mIc[i] + 1;
                if (mq[i].size() == DEPTH && !doPop) begin
                    mOv[i] = 1'b1;
                    if (mWrap(i)) begin
                        void'(mq[i].pop_front());
                        mq[i].push_back(e);
                    end
                end else begin
                    doPush = 1'b1;
                end
                if (!rw && hl) mFz[i] = 1'b1;
            end
            if (wdog) begin
                mFz[i] = 1'b1;
                mLh[i] = 1'b1;
            end
        end
        if (doPop) void'(mq[i].pop_front());
        if (doPush) mq[i].push_back(e);
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nVec++;
        assert (got === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_valid%0d", i), 64'(rv[i]), 64'(mq[i].size() > 0));
            chk($sformatf("occ%0d", i), 64'(occ[i]), 64'(mq[i].size()));
            chk($sformatf("inst%0d", i), 64'(ic[i]), 64'(mIc[i]));
            chk($sformatf("cycle%0d", i), 64'(cc[i]), 64'(mCc[i]));
            chk($sformatf("ovf%0d", i), 64'(ov[i]), 64'(mOv[i]));
            chk($sformatf("frozen%0d", i), 64'(fz[i]), 64'(mFz[i]));
            chk($sformatf("limit%0d", i), 64'(lh[i]), 64'(mLh[i]));
            if (mq[i].size() > 0)
                chk($sformatf("entry%0d", i), 64'(re[i]), 64'(mq[i][0]));
        end
    endtask

    task automatic step();
        for (int i = 0; i < 3; i++) mStep(i);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic setRet(input logic iv, input logic [15:0] ipc,
                          input logic irw, input logic [3:0] irg,
                          input logic [15:0] iwd, input logic imw,
                          input logic [15:0] ima, input logic [15:0] imd,
                          input logic ihl);
        v = iv; pc = ipc; rw = irw; rg = irg; wd = iwd;
        mw = imw; ma = ima; md = imd; hl = ihl;
    endtask

    task automatic idle();
        setRet(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic doClr();
        idle();
        rdy = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mReset(i);
        #1 rst_n = 1'b0;
        #20;
        checkAll();
        rst_n = 1'b1;

        // Three retires then drain: kinds 0, 2, 3
        doClr();
        setRet(1'b1, 16'h0000, 1'b1, 4'd3, 16'h0005, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        setRet(1'b1, 16'h0002, 1'b0, 4'd0, 16'h0, 1'b1, 16'h0010, 16'h00AA, 1'b0);
        step();
        setRet(1'b1, 16'h0004, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        idle();
        chk("t1_occ", 64'(occ[0]), 64'd3);
        chk("t1_inst", 64'(ic[0]), 64'd3);
        expE = {2'd0, 16'h0000, 4'd3, 16'h0000, 16'h0005};
        chk("t1_e0", 64'(re[0]), 64'(expE));
        rdy = 1'b1;
        step();
        expE = {2'd2, 16'h0002, 4'd0, 16'h0010, 16'h00AA};
        chk("t1_e1", 64'(re[0]), 64'(expE));
        step();
        expE = {2'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000};
        chk("t1_e2", 64'(re[0]), 64'(expE));
        step();
        chk("t1_empty", 64'(rv[0]), 64'd0);

        // Six retires with no reads: stop mode drops, wrap overwrites
        doClr();
        for (int k = 0; k < 6; k++) begin
            setRet(1'b1, 16'(2 * k), 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
            step();
        end
        idle();
        chk("t2_occ", 64'(occ[0]), 64'd4);
        chk("t2_ovf", 64'(ov[0]), 64'd1);
        chk("t2_head", 64'(re[0][51:36]), 64'h0);
        chk("t2_inst", 64'(ic[0]), 64'd6);
        chk("t2w_ovf", 64'(ov[1]), 64'd1);
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2w_pc%0d", k), 64'(re[1][51:36]), 64'(4 + 2 * k));
            step();
        end
        chk("t2w_empty", 64'(rv[1]), 64'd0);

        // HALT freezes capture; clr resumes RUN
        doClr();
        setRet(1'b1, 16'h001E, 1'b1, 4'd1, 16'h0011, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        setRet(1'b1, 16'h0020, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
        step();
        chk("t3_frozen", 64'(fz[0]), 64'd1);
        chk("t3_cyc", 64'(cc[0]), 64'd2);
        setRet(1'b1, 16'h0022, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        step();
        step();
        idle();
        chk("t3_cychold", 64'(cc[0]), 64'd2);
        chk("t3_inst", 64'(ic[0]), 64'd2);
        chk("t3_occ", 64'(occ[0]), 64'd2);
        rdy = 1'b1;
        step();
        expE = {2'd1, 16'h0020, 4'd0, 16'h0000, 16'h0000};
        chk("t3_halt", 64'(re[0]), 64'(expE));
        step();
        chk("t3_last", 64'(rv[0]), 64'd0);
        doClr();
        chk("t3_run", 64'(fz[0]), 64'd0);
        chk("t3_cyc0", 64'(cc[0]), 64'd0);
        chk("t3_inst0", 64'(ic[0]), 64'd0);

        // Watchdog at 10 cycles on the third instance
        doClr();
        for (int k = 0; k < 12; k++) step();
        chk("t4_limit", 64'(lh[2]), 64'd1);
        chk("t4_frozen", 64'(fz[2]), 64'd1);
        chk("t4_cyc", 64'(cc[2]), 64'd10);
        chk("t4_nowd", 64'(lh[0]), 64'd0);
        chk("t4_cyc0", 64'(cc[0]), 64'd12);

        // Full buffer with simultaneous push and pop
        doClr();
        for (int k = 0; k < 4; k++) begin
            setRet(1'b1, 16'(16'h40 + 2 * k), 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
            step();
        end
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            setRet(1'b1, 16'(16'h80 + 2 * k), 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
            step();
            chk($sformatf("t5_occ%0d", k), 64'(occ[0]), 64'd4);
            chk($sformatf("t5_ovf%0d", k), 64'(ov[0]), 64'd0);
        end

        // Asynchronous reset in mid-stream
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) mReset(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_rv%0d", i), 64'(rv[i]), 64'd0);
            chk($sformatf("t6_occ%0d", i), 64'(occ[i]), 64'd0);
        end
        #2 rst_n = 1'b1;
        idle();
        rdy = 1'b0;
        step();

        // Randomized traffic against the queue models
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            rw  = ($urandom_range(0, 9) < 4);
            mw  = ($urandom_range(0, 9) < 3);
            hl  = ($urandom_range(0, 49) == 0);
            rdy = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 29) == 0);
            pc  = 16'($urandom);
            wd  = 16'($urandom);
            ma  = 16'($urandom);
            md  = 16'($urandom);
            rg  = 4'($urandom);
            step();
        end
        clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
